// File: rtl/clock_display_driver_if.sv
// Time-of-day inputs and multiplexed seven-segment outputs of the clock display driver.
// The master side supplies the time and watches the display; the slave side is the driver.
interface clock_display_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [5:0] hours;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output seconds, minutes, hours,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  seconds, minutes, hours,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/clock_display_driver.sv
// Six-digit HH:MM:SS multiplexed common-anode display driver with per-frame time snapshot,
// per-field range dashes, optional hours leading-zero blanking and a seconds-rate colon.
module clock_display_driver #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_HOUR_LZ = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  clock_display_if.slave  disp
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] r_prescaler;
  logic [2:0]    r_digit_idx;
  logic [5:0]    r_snap_sec;
  logic [5:0]    r_snap_min;
  logic [5:0]    r_snap_hr;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_capture;
  logic [5:0]    w_sec_src;
  logic [5:0]    w_value;
  logic [5:0]    w_limit;
  logic [3:0]    w_tens;
  logic [3:0]    w_ones;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;
  logic [5:0]    w_an_next;

  function automatic logic [6:0] f_seg_code(input logic [3:0] d);
    case (d)
      4'd0:    f_seg_code = 7'h40;
      4'd1:    f_seg_code = 7'h79;
      4'd2:    f_seg_code = 7'h24;
      4'd3:    f_seg_code = 7'h30;
      4'd4:    f_seg_code = 7'h19;
      4'd5:    f_seg_code = 7'h12;
      4'd6:    f_seg_code = 7'h02;
      4'd7:    f_seg_code = 7'h78;
      4'd8:    f_seg_code = 7'h00;
      4'd9:    f_seg_code = 7'h10;
      default: f_seg_code = 7'h7F;
    endcase
  endfunction

  assign w_tick    = (r_prescaler == PW'(REFRESH_DIV - 1));
  assign w_capture = (r_digit_idx == 3'd0);
  // Digit 0 shows the live value on the very tick it is being captured.
  assign w_sec_src = w_capture ? disp.seconds : r_snap_sec;

  always_comb begin
    w_value = w_sec_src;
    w_limit = 6'd59;
    case (r_digit_idx)
      3'd0, 3'd1: begin w_value = w_sec_src;  w_limit = 6'd59; end
      3'd2, 3'd3: begin w_value = r_snap_min; w_limit = 6'd59; end
      3'd4, 3'd5: begin w_value = r_snap_hr;  w_limit = 6'd23; end
      default:    begin w_value = 6'd0;       w_limit = 6'd59; end
    endcase
  end

  assign w_tens  = 4'(w_value / 6'd10);
  assign w_ones  = 4'(w_value % 6'd10);
  assign w_digit = r_digit_idx[0] ? w_tens : w_ones;

  always_comb begin
    w_seg_next = f_seg_code(w_digit);
    if (w_value > w_limit) begin
      w_seg_next = 7'h3F;
    end else if (BLANK_HOUR_LZ && (r_digit_idx == 3'd5) && (w_tens == 4'd0)) begin
      w_seg_next = 7'h7F;
    end
  end

  assign w_dp_next = !(((r_digit_idx == 3'd2) || (r_digit_idx == 3'd4)) &&
                       (r_snap_sec <= 6'd59) && !r_snap_sec[0]);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_an
      assign w_an_next[gi] = (r_digit_idx != 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler   <= '0;
      r_digit_idx   <= 3'd0;
      r_snap_sec    <= 6'd0;
      r_snap_min    <= 6'd0;
      r_snap_hr     <= 6'd0;
      r_an          <= 6'h3F;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_prescaler <= '0;
        r_an        <= w_an_next;
        r_seg       <= w_seg_next;
        r_dp        <= w_dp_next;
        r_digit_idx <= (r_digit_idx == 3'd5) ? 3'd0 : r_digit_idx + 3'd1;
        if (w_capture) begin
          r_snap_sec    <= disp.seconds;
          r_snap_min    <= disp.minutes;
          r_snap_hr     <= disp.hours;
          r_frame_start <= 1'b1;
        end
      end else begin
        r_prescaler <= r_prescaler + 1'b1;
      end
    end
  end

  assign disp.an          = r_an;
  assign disp.seg         = r_seg;
  assign disp.dp          = r_dp;
  assign disp.frame_start = r_frame_start;
endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver: vector table, hand-written corner sequences and a
// randomized run checked every cycle against an edge-counting reference model.
module tb_clock_display_driver;
  localparam int DIV = 4;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_on   = 0;

  clock_display_if if0 ();
  clock_display_if if1 ();

  clock_display_driver #(.REFRESH_DIV(DIV), .BLANK_HOUR_LZ(1'b0)) dut0 (
    .clk(clk), .reset(reset), .disp(if0)
  );
  clock_display_driver #(.REFRESH_DIV(DIV), .BLANK_HOUR_LZ(1'b1)) dut1 (
    .clk(clk), .reset(reset), .disp(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_time(input logic [5:0] s, input logic [5:0] m, input logic [5:0] h);
    if0.seconds = s; if0.minutes = m; if0.hours = h;
    if1.seconds = s; if1.minutes = m; if1.hours = h;
  endtask

  // Reference model: counts edges since reset release; every DIV-th edge is a tick.
  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int slot, input int s, input int m, input int h,
                                          input bit blank);
    int v, lim, d;
    v   = (slot < 2) ? s : (slot < 4) ? m : h;
    lim = (slot < 4) ? 59 : 23;
    if (v > lim) return 7'h3F;
    d = (slot % 2 == 1) ? v / 10 : v % 10;
    if (blank && slot == 5 && d == 0) return 7'h7F;
    return code_of(d);
  endfunction

  function automatic logic exp_dp(input int slot, input int snap_sec);
    if ((slot == 2 || slot == 4) && snap_sec <= 59 && snap_sec % 2 == 0) return 1'b0;
    return 1'b1;
  endfunction

  int         m_n;
  int         slot_now;
  logic [5:0] m_sec, m_min, m_hr, sec_view;
  logic [5:0] e_an;
  logic [6:0] e_seg0, e_seg1;
  logic       e_dp, e_fs;

  assign slot_now = ((m_n + 1) / DIV - 1) % 6;
  assign sec_view = (slot_now == 0) ? if0.seconds : m_sec;

  always @(posedge clk) begin
    if (reset) begin
      m_n <= 0; m_sec <= 6'd0; m_min <= 6'd0; m_hr <= 6'd0;
      e_an <= 6'h3F; e_seg0 <= 7'h7F; e_seg1 <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
    end else begin
      m_n  <= m_n + 1;
      e_fs <= 1'b0;
      if ((m_n + 1) % DIV == 0) begin
        e_an   <= ~(6'd1 << slot_now);
        e_seg0 <= exp_seg(slot_now, int'(sec_view), int'(m_min), int'(m_hr), 1'b0);
        e_seg1 <= exp_seg(slot_now, int'(sec_view), int'(m_min), int'(m_hr), 1'b1);
        e_dp   <= (slot_now == 0) ? 1'b1 : exp_dp(slot_now, int'(m_sec));
        if (slot_now == 0) begin
          m_sec <= if0.seconds; m_min <= if0.minutes; m_hr <= if0.hours;
          e_fs  <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_an0",  32'(if0.an),          32'(e_an));
      check("model_seg0", 32'(if0.seg),         32'(e_seg0));
      check("model_dp0",  32'(if0.dp),          32'(e_dp));
      check("model_fs0",  32'(if0.frame_start), 32'(e_fs));
      check("model_an1",  32'(if1.an),          32'(e_an));
      check("model_seg1", 32'(if1.seg),         32'(e_seg1));
      check("model_dp1",  32'(if1.dp),          32'(e_dp));
      check("model_fs1",  32'(if1.frame_start), 32'(e_fs));
    end
  end

  typedef struct {
    logic [5:0]       sec, min, hr;
    logic [0:5][6:0]  seg;
    logic [6:0]       seg5b;
    logic [0:5]       dp;
  } vec_t;
  vec_t tbl[8];

  logic [0:5][5:0] c_an0, c_an1;
  logic [0:5][6:0] c_seg0, c_seg1;
  logic [0:5]      c_dp0, c_dp1;

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if0.frame_start !== 1'b1 && n < 100);
    if (if0.frame_start !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL fs_timeout actual=no_pulse required=pulse within 100 cycles");
    end
  endtask

  task automatic capture_frame();
    wait_fs();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) repeat (DIV) @(negedge clk);
      c_an0[k] = if0.an;  c_seg0[k] = if0.seg; c_dp0[k] = if0.dp;
      c_an1[k] = if1.an;  c_seg1[k] = if1.seg; c_dp1[k] = if1.dp;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]       exp_an;
    logic [6:0]       tail[3];
    logic [0:5][6:0]  nxt;
    int               cyc;

    tbl[0] = '{6'd56, 6'd34, 6'd12, {7'h02,7'h12,7'h19,7'h30,7'h24,7'h79}, 7'h79, 6'b110101};
    tbl[1] = '{6'd60, 6'd7,  6'd24, {7'h3F,7'h3F,7'h78,7'h40,7'h3F,7'h3F}, 7'h3F, 6'b111111};
    tbl[2] = '{6'd0,  6'd0,  6'd5,  {7'h40,7'h40,7'h40,7'h40,7'h12,7'h40}, 7'h7F, 6'b110101};
    tbl[3] = '{6'd0,  6'd0,  6'd0,  {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 7'h7F, 6'b110101};
    tbl[4] = '{6'd59, 6'd59, 6'd23, {7'h10,7'h12,7'h10,7'h12,7'h30,7'h24}, 7'h24, 6'b111111};
    tbl[5] = '{6'd7,  6'd48, 6'd9,  {7'h78,7'h40,7'h00,7'h19,7'h10,7'h40}, 7'h7F, 6'b111111};
    tbl[6] = '{6'd18, 6'd63, 6'd1,  {7'h00,7'h79,7'h3F,7'h3F,7'h79,7'h40}, 7'h7F, 6'b110101};
    tbl[7] = '{6'd33, 6'd21, 6'd31, {7'h30,7'h30,7'h79,7'h24,7'h3F,7'h3F}, 7'h3F, 6'b111111};

    reset = 1'b1;
    set_time(6'd56, 6'd34, 6'd12);
    @(posedge clk);
    @(negedge clk);
    chk_on = 1;

    // Reset held for 10 cycles, then first tick on the DIV-th edge.
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("rst_an",  32'(if0.an),  32'h3F);
      check("rst_seg", 32'(if0.seg), 32'h7F);
      check("rst_dp",  32'(if0.dp),  32'h1);
      check("rst_fs",  32'(if0.frame_start), 32'h0);
    end
    reset = 1'b0;
    for (int e = 1; e <= DIV; e++) begin
      @(negedge clk);
      if (e < DIV) begin
        check("pre_tick_an", 32'(if0.an), 32'h3F);
      end else begin
        check("first_tick_an",  32'(if0.an),  32'h3E);
        check("first_tick_seg", 32'(if0.seg), 32'h02);
        check("first_tick_fs",  32'(if0.frame_start), 32'h1);
      end
    end
    $display("reset/first-tick sequence done");

    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (if0.frame_start !== 1'b1 && cyc < 100);
    check("frame_period", 32'(cyc), 32'(6 * DIV));
    $display("frame period measured %0d cycles", cyc);

    for (int v = 0; v < 8; v++) begin
      set_time(tbl[v].sec, tbl[v].min, tbl[v].hr);
      capture_frame();
      for (int k = 0; k < 6; k++) begin
        exp_an = 6'h3F ^ (6'd1 << k);
        check("vec_an0",  32'(c_an0[k]),  32'(exp_an));
        check("vec_an1",  32'(c_an1[k]),  32'(exp_an));
        check("vec_seg0", 32'(c_seg0[k]), 32'(tbl[v].seg[k]));
        check("vec_seg1", 32'(c_seg1[k]), 32'((k == 5) ? tbl[v].seg5b : tbl[v].seg[k]));
        check("vec_dp0",  32'(c_dp0[k]),  32'(tbl[v].dp[k]));
        check("vec_dp1",  32'(c_dp1[k]),  32'(tbl[v].dp[k]));
      end
      $display("vector %0d time %0d:%0d:%0d seg=%h", v, tbl[v].hr, tbl[v].min, tbl[v].sec, c_seg0);
    end

    // Inputs change mid-frame; rest of frame keeps the old snapshot.
    set_time(6'd56, 6'd34, 6'd12);
    wait_fs();
    repeat (2 * DIV) @(negedge clk);
    set_time(6'd59, 6'd59, 6'd23);
    tail[0] = 7'h30; tail[1] = 7'h24; tail[2] = 7'h79;
    for (int k = 0; k < 3; k++) begin
      repeat (DIV) @(negedge clk);
      check("coh_old_seg", 32'(if0.seg), 32'(tail[k]));
    end
    capture_frame();
    nxt = {7'h10, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
    for (int k = 0; k < 6; k++) begin
      check("coh_new_seg", 32'(c_seg0[k]), 32'(nxt[k]));
      check("coh_new_dp",  32'(c_dp0[k]),  32'h1);
    end
    $display("snapshot coherence sequence done");

    // One-cycle reset landing on the idx3 tick edge.
    set_time(6'd56, 6'd34, 6'd12);
    wait_fs();
    repeat (3 * DIV - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_an",  32'(if0.an),  32'h3F);
    check("midrst_seg", 32'(if0.seg), 32'h7F);
    check("midrst_dp",  32'(if0.dp),  32'h1);
    check("midrst_fs",  32'(if0.frame_start), 32'h0);
    for (int e = 1; e <= DIV; e++) begin
      @(negedge clk);
      if (e < DIV) begin
        check("midrst_wait_an", 32'(if0.an), 32'h3F);
      end else begin
        check("midrst_idx0_an", 32'(if0.an), 32'h3E);
        check("midrst_idx0_fs", 32'(if0.frame_start), 32'h1);
      end
    end
    $display("mid-frame reset sequence done");

    for (int it = 0; it < 300; it++) begin
      logic [5:0] s, m, h;
      int hold;
      if ($urandom_range(0, 3) == 0) begin
        s = 6'($urandom_range(0, 63)); m = 6'($urandom_range(0, 63)); h = 6'($urandom_range(0, 63));
      end else begin
        s = 6'($urandom_range(0, 59)); m = 6'($urandom_range(0, 59)); h = 6'($urandom_range(0, 23));
      end
      set_time(s, m, h);
      hold = $urandom_range(1, 30);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
      end
      repeat (hold) @(negedge clk);
      $display("random %0d time %0d:%0d:%0d hold=%0d", it, h, m, s, hold);
    end

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
